id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameter PC_W, default 15, PC/address width.
REQ-002 Parameter XLEN, default 32, data and instruction width.
REQ-003 Parameter NREG, default 32, register-file depth; x0 hardwired to zero.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  reset, synchronous and active-high (level 1 resets on the clock edge).
REQ-006 pc_IF_ID  input  PC_W  PC of the word currently fetched.
REQ-007 instruction_IF_ID  input  XLEN  fetched instruction; synchronous ROM, so it is valid one cycle after its PC.
REQ-008 flush_EXE  input  1  taken branch/jal/jalr resolved in EXE.
REQ-009 memread_EXE, rd_EXE  input  1, 5  load-in-EXE flag and its destination register.
REQ-010 wb_en_WB, wb_rd_WB, wb_data_WB  input  1, 5, XLEN  register-file write port.
REQ-011 pc_write_HZRD  output  1  PC write enable to fetch (0 = stall).
REQ-012 valid_ID_EXE, pc_ID_EXE, rs1_data_ID_EXE, rs2_data_ID_EXE, imm_ID_EXE  output  1, PC_W, XLEN, XLEN, XLEN  registered decode results.
REQ-013 rs1_ID_EXE, rs2_ID_EXE, rd_ID_EXE  output  5 each  register indices for forwarding.
REQ-014 ctrl_ID_EXE  output  12  packed control word (alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch, jal, jalr).
REQ-015 illegal_ID  output  1  sticky illegal-opcode flag.

Function
REQ-016 Internal IF/ID slot SHALL hold {pc, instruction, valid}; pc is delayed one cycle to align with the ROM data.
REQ-017 Decode SHALL support RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP; immediates sign-extended to XLEN per I/S/B/U/J formats.
REQ-018 All ID/EXE outputs SHALL be registered; latency is one cycle from instruction in slot to values on outputs.
REQ-019 Load-use hazard: slot valid, memread_EXE=1, rd_EXE≠0 and rd_EXE equal to a used rs1/rs2 → pc_write_HZRD=0, slot held, bubble (valid=0, ctrl=0) written to ID/EXE.
REQ-020 pc_write_HZRD SHALL be combinational and 1 in every non-hazard cycle.
REQ-021 flush_EXE=1 SHALL load a squash counter with 2; while counter≠0 the slot is invalid, ID/EXE receives bubbles, counter decrements each cycle.
REQ-022 Flush SHALL take priority over hazard stall in the same cycle; pc_write_HZRD=1 on flush.
REQ-023 flush_EXE during a nonzero count SHALL reload the counter to 2.
REQ-024 Register file SHALL write on wb_en_WB=1 and wb_rd_WB≠0; writes to x0 ignored; reads of x0 return 0.
REQ-025 Read of a register written in the same cycle SHALL return wb_data_WB (write-through bypass).
REQ-026 Unknown opcode in a valid slot SHALL produce a bubble and set illegal_ID until reset.
REQ-027 Bubbles SHALL carry ctrl=0, imm=0, rd=0; pc, rs1/rs2 data are don't-care.

Reset
REQ-028 With reset_n=1 at an edge: all registers x1..x31, slot, squash counter, all ID/EXE outputs and illegal_ID SHALL become 0.
REQ-029 Reset SHALL override simultaneous flush, stall and register-file write.
REQ-030 First valid slot SHALL occur on the second edge after reset deasserts.

Structure
REQ-031 Shared package SHALL hold opcode constants, alu_op encodings, ctrl-word field offsets and the 12-bit ctrl typedef.
REQ-032 Register file SHALL be the sub-module reg_file (2 read, 1 write, bypass); decoder and immediate generation stay in id_stage.

Verification
REQ-033 Write x5=0x12345678 via WB, then decode add x6,x5,x0 → rs1_data_ID_EXE=0x12345678, ctrl reg_write=1, alu_src=0.
REQ-034 lw x7,0(x1) in EXE (memread_EXE=1, rd_EXE=7) with add x8,x7,x2 in slot → pc_write_HZRD=0 one cycle, one bubble, then add issued.
REQ-035 flush_EXE=1 pulse → exactly two bubbles on valid_ID_EXE, then next instruction valid; flush plus hazard same cycle → pc_write_HZRD=1.
REQ-036 WB writes x3=0xDEADBEEF while addi x4,x3,-1 decodes → rs1_data=0xDEADBEEF, imm=0xFFFFFFFF; write to x0 → x0 reads 0.
REQ-037 Opcode 0x7F in slot → bubble, illegal_ID=1 and held; reset_n=1 mid-stall → all outputs 0 next edge, illegal_ID cleared.

Source files
------------

// File: rtl/id_stage_pkg.sv
// Shared decode definitions for the ID stage: RV32I opcodes, ALU operation codes
// and the 12-bit control word handed to EXE.
package id_stage_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Branch compares reuse the ALU: a nonzero result means "taken".
    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_ADDPC = 4'd11,
        ALU_EQ    = 4'd12,
        ALU_NE    = 4'd13,
        ALU_GE    = 4'd14,
        ALU_GEU   = 4'd15
    } alu_op_e;

    localparam int CTRL_W          = 12;
    localparam int CTRL_JALR       = 0;
    localparam int CTRL_JAL        = 1;
    localparam int CTRL_BRANCH     = 2;
    localparam int CTRL_MEM_TO_REG = 3;
    localparam int CTRL_REG_WRITE  = 4;
    localparam int CTRL_MEM_WRITE  = 5;
    localparam int CTRL_MEM_READ   = 6;
    localparam int CTRL_ALU_SRC    = 7;
    localparam int CTRL_ALU_OP_LSB = 8;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
        logic    jal;
        logic    jalr;
    } ctrl_t;

    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic alu_op_e alu_from_branch(input logic [2:0] funct3);
        case (funct3)
            3'b001:  return ALU_NE;
            3'b100:  return ALU_SLT;
            3'b101:  return ALU_GE;
            3'b110:  return ALU_SLTU;
            3'b111:  return ALU_GEU;
            default: return ALU_EQ;
        endcase
    endfunction

endpackage

// File: rtl/id_stage_reg_file.sv
// Two-read, one-write register file with x0 hardwired to zero and write-through
// bypass so a register written this cycle reads back its new value.
module reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREG];
    logic            write_ok;

    assign write_ok = we && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (write_ok) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0)                 ? '0    :
                    (write_ok && (waddr == raddr1)) ? wdata : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0)                 ? '0    :
                    (write_ok && (waddr == raddr2)) ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage.sv
// Decode stage: IF/ID slot, RV32I decoder and immediate generator, load-use hazard
// stall, branch-flush squashing and the registered ID/EXE outputs.
module id_stage
    import id_stage_pkg::*;
#(
    parameter int PC_W = 15,
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [PC_W-1:0] pc_IF_ID,
    input  logic [XLEN-1:0] instruction_IF_ID,
    input  logic            flush_EXE,
    input  logic            memread_EXE,
    input  logic [4:0]      rd_EXE,
    input  logic            wb_en_WB,
    input  logic [4:0]      wb_rd_WB,
    input  logic [XLEN-1:0] wb_data_WB,
    output logic            pc_write_HZRD,
    output logic            valid_ID_EXE,
    output logic [PC_W-1:0] pc_ID_EXE,
    output logic [XLEN-1:0] rs1_data_ID_EXE,
    output logic [XLEN-1:0] rs2_data_ID_EXE,
    output logic [XLEN-1:0] imm_ID_EXE,
    output logic [4:0]      rs1_ID_EXE,
    output logic [4:0]      rs2_ID_EXE,
    output logic [4:0]      rd_ID_EXE,
    output logic [11:0]     ctrl_ID_EXE,
    output logic            illegal_ID
);

    logic            warm;
    logic            slot_valid_q;
    logic [PC_W-1:0] slot_pc;
    logic [XLEN-1:0] slot_inst_q;
    logic            slot_held;
    logic [1:0]      squash_cnt;

    logic [XLEN-1:0] inst;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm_ext;
    ctrl_t           ctrl;
    logic            use_rs1, use_rs2, writes_rd, legal;
    logic [XLEN-1:0] rs1_data, rs2_data;

    logic [1:0]      squash_eff;
    logic            squashing, slot_valid, stall, issue;

    // While stalled the ROM has already moved on, so the held word is replayed from slot_inst_q.
    assign inst   = slot_held ? slot_inst_q : instruction_IF_ID;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign rd     = inst[11:7];

    always_comb begin
        ctrl      = '0;
        imm32     = '0;
        use_rs1   = 1'b0;
        use_rs2   = 1'b0;
        writes_rd = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OPC_LUI: begin
                ctrl.alu_op = ALU_PASSB; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                writes_rd = 1'b1; imm32 = {inst[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                ctrl.alu_op = ALU_ADDPC; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                writes_rd = 1'b1; imm32 = {inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                ctrl.jal = 1'b1; ctrl.reg_write = 1'b1; writes_rd = 1'b1;
                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            OPC_JALR: begin
                ctrl.jalr = 1'b1; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                writes_rd = 1'b1; use_rs1 = 1'b1; imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_BRANCH: begin
                ctrl.alu_op = alu_from_branch(funct3); ctrl.branch = 1'b1;
                use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LOAD: begin
                ctrl.alu_src = 1'b1; ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_OP_IMM: begin
                // Only the shift-right encoding uses bit 30 as a selector; elsewhere it is immediate.
                ctrl.alu_op = alu_from_funct(funct3, (funct3 == 3'b101) && inst[30]);
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1;
                imm32 = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_OP: begin
                ctrl.alu_op = alu_from_funct(funct3, inst[30]);
                ctrl.reg_write = 1'b1; writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    assign imm_ext = XLEN'(signed'(imm32));

    // A flush counts as the first squashed cycle, so one pulse yields exactly two bubbles.
    assign squash_eff    = flush_EXE ? 2'd2 : squash_cnt;
    assign squashing     = (squash_eff != 2'd0);
    assign slot_valid    = slot_valid_q && !squashing;
    assign stall         = slot_valid && memread_EXE && (rd_EXE != 5'd0) &&
                           ((use_rs1 && (rd_EXE == rs1)) || (use_rs2 && (rd_EXE == rs2)));
    assign pc_write_HZRD = !stall;
    assign issue         = slot_valid && legal && !stall;

    reg_file #(.XLEN(XLEN), .NREG(NREG)) u_reg_file (
        .clk    (clk),
        .reset  (reset_n),
        .we     (wb_en_WB),
        .waddr  (wb_rd_WB),
        .wdata  (wb_data_WB),
        .raddr1 (rs1),
        .rdata1 (rs1_data),
        .raddr2 (rs2),
        .rdata2 (rs2_data)
    );

    // The warm-up flag keeps the slot empty until the ROM output reflects a post-reset fetch.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            warm         <= 1'b0;
            slot_valid_q <= 1'b0;
            slot_pc      <= '0;
            slot_inst_q  <= '0;
            slot_held    <= 1'b0;
            squash_cnt   <= 2'd0;
        end else begin
            warm        <= 1'b1;
            squash_cnt  <= squashing ? (squash_eff - 2'd1) : 2'd0;
            slot_inst_q <= inst;
            slot_held   <= stall;
            if (!stall) begin
                slot_pc      <= pc_IF_ID;
                slot_valid_q <= warm;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            valid_ID_EXE    <= 1'b0;
            pc_ID_EXE       <= '0;
            rs1_data_ID_EXE <= '0;
            rs2_data_ID_EXE <= '0;
            imm_ID_EXE      <= '0;
            rs1_ID_EXE      <= '0;
            rs2_ID_EXE      <= '0;
            rd_ID_EXE       <= '0;
            ctrl_ID_EXE     <= '0;
            illegal_ID      <= 1'b0;
        end else begin
            valid_ID_EXE    <= issue;
            pc_ID_EXE       <= issue ? slot_pc : '0;
            rs1_data_ID_EXE <= issue ? rs1_data : '0;
            rs2_data_ID_EXE <= issue ? rs2_data : '0;
            imm_ID_EXE      <= issue ? imm_ext : '0;
            rs1_ID_EXE      <= (issue && use_rs1) ? rs1 : 5'd0;
            rs2_ID_EXE      <= (issue && use_rs2) ? rs2 : 5'd0;
            rd_ID_EXE       <= (issue && writes_rd) ? rd : 5'd0;
            ctrl_ID_EXE     <= issue ? ctrl : '0;
            illegal_ID      <= illegal_ID || (slot_valid && !legal);
        end
    end

endmodule
